// File: rtl/fp16_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : fp16_pkg
//  Purpose  : Constants and types shared by the FP16 vector packer slice.
//  Revision : 1.0  initial release
// ============================================================================
package fp16_pkg;

  // Element width of an IEEE half-precision value
  localparam int FP16_W = 16;

  // Positive zero; unfilled vector slots are forced to this so they add nothing
  localparam logic [FP16_W-1:0] FP16_POS_ZERO = 16'h0000;

  // Element count of the adder-tree input vector
  localparam int VEC64_N = 64;

  typedef logic [FP16_W-1:0] fp16_t;

  // Width needed to hold a count in the range 0..n
  function automatic int count_width(input int n);
    return $clog2(n) + 1;
  endfunction

endpackage : fp16_pkg
`default_nettype wire

// File: rtl/fp16_vec64_packer_if.sv
`default_nettype none
// ============================================================================
//  Module   : fp16_vec64_packer_if
//  Purpose  : Narrow element stream in, wide packed vector out.
//             master = producer/consumer side, slave = packer side.
//  Revision : 1.0  initial release
// ============================================================================
interface fp16_vec64_packer_if #(
  parameter int N = fp16_pkg::VEC64_N,
  parameter int W = fp16_pkg::FP16_W
);

  localparam int CW = $clog2(N) + 1;

  // Element stream
  logic [W-1:0]   in_data;
  logic           in_valid;
  logic           in_last;
  logic           in_ready;

  // Packed vector stream
  logic [N*W-1:0] out_data;
  logic           out_valid;
  logic           out_ready;
  logic [CW-1:0]  out_count;

  modport master (
    output in_data,
    output in_valid,
    output in_last,
    input  in_ready,
    input  out_data,
    input  out_valid,
    output out_ready,
    input  out_count
  );

  modport slave (
    input  in_data,
    input  in_valid,
    input  in_last,
    output in_ready,
    output out_data,
    output out_valid,
    input  out_ready,
    output out_count
  );

endinterface : fp16_vec64_packer_if
`default_nettype wire

// File: rtl/fp16_vec_bank.sv
`default_nettype none
// ============================================================================
//  Module   : fp16_vec_bank
//  Purpose  : One ping-pong bank: N element slots, per-slot valid mask,
//             element count and full flag. Reads return +0.0 for slots that
//             were never written in the current vector.
//  Revision : 1.0  initial release
// ============================================================================
module fp16_vec_bank #(
  parameter int N = fp16_pkg::VEC64_N,
  parameter int W = fp16_pkg::FP16_W
) (
  input  wire logic                    clk,
  input  wire logic                    rst,
  // write port
  input  wire logic                    wr_en,
  input  wire logic [$clog2(N)-1:0]    wr_idx,
  input  wire logic [W-1:0]            wr_data,
  input  wire logic                    wr_complete,
  input  wire logic [$clog2(N):0]      wr_count,
  // clear port (read handshake)
  input  wire logic                    clr,
  // status and masked read data
  output logic                         full,
  output logic [$clog2(N):0]           count,
  output logic [N*W-1:0]               data
);

  import fp16_pkg::*;

  localparam int CW = $clog2(N) + 1;

  logic [W-1:0]  r_data [N];
  logic [N-1:0]  r_mask;
  logic [CW-1:0] r_count;
  logic          r_full;

  // Control state: mask, count and full; a clear drops the whole vector
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_mask  <= '0;
      r_count <= '0;
      r_full  <= 1'b0;
    end else if (clr) begin
      r_mask  <= '0;
      r_count <= '0;
      r_full  <= 1'b0;
    end else if (wr_en) begin
      r_mask[wr_idx] <= 1'b1;
      if (wr_complete) begin
        r_full  <= 1'b1;
        r_count <= wr_count;
      end
    end
  end

  // Element storage; no reset needed because the mask gates every read
  always_ff @(posedge clk) begin
    if (wr_en) begin
      r_data[wr_idx] <= wr_data;
    end
  end

  // Masked read: untouched slots present +0.0 to the adder tree
  for (genvar i = 0; i < N; i++) begin : g_slot
    assign data[i*W +: W] = r_mask[i] ? r_data[i] : W'(FP16_POS_ZERO);
  end

  assign full  = r_full;
  assign count = r_count;

endmodule : fp16_vec_bank
`default_nettype wire

// File: rtl/fp16_vec64_packer.sv
`default_nettype none
// ============================================================================
//  Module   : fp16_vec64_packer
//  Purpose  : Serial-to-parallel front end for the 64-input FP16 adder tree.
//             Collects one element per beat into one of two ping-pong banks
//             and presents completed vectors on the wide side.
//  Revision : 1.0  initial release
// ============================================================================
module fp16_vec64_packer #(
  parameter int N = fp16_pkg::VEC64_N,
  parameter int W = fp16_pkg::FP16_W
) (
  input  wire logic          clk,
  input  wire logic          rst,
  fp16_vec64_packer_if.slave bus
);

  import fp16_pkg::*;

  localparam int IW = $clog2(N);
  localparam int CW = IW + 1;

  // Fill position in the write bank and the two bank pointers
  logic [IW-1:0]  r_cnt;
  logic           r_wr_bank;
  logic           r_rd_bank;

  // Bank status and data
  logic [1:0]     w_full;
  logic [CW-1:0]  w_count [2];
  logic [N*W-1:0] w_data  [2];

  // Handshake decode
  logic           w_in_ready;
  logic           w_out_valid;
  logic           w_beat;
  logic           w_complete;
  logic           w_rd_hs;
  logic [CW-1:0]  w_wr_count;
  logic [1:0]     w_wr_sel;
  logic [1:0]     w_clr_sel;

  // in_ready looks only at registered state so it never loops through in_valid
  assign w_in_ready  = ~w_full[r_wr_bank];
  assign w_out_valid = w_full[r_rd_bank];

  assign w_beat      = bus.in_valid & w_in_ready;
  assign w_complete  = w_beat & ((r_cnt == IW'(N-1)) | bus.in_last);
  assign w_rd_hs     = w_out_valid & bus.out_ready;
  assign w_wr_count  = {1'b0, r_cnt} + CW'(1);

  // Route the write and clear strobes to the selected banks. The bank being
  // written is never full while the bank being read always is, so the two
  // strobes cannot land on the same bank in one cycle.
  always_comb begin
    w_wr_sel             = 2'b00;
    w_clr_sel            = 2'b00;
    w_wr_sel[r_wr_bank]  = w_beat;
    w_clr_sel[r_rd_bank] = w_rd_hs;
  end

  for (genvar b = 0; b < 2; b++) begin : g_bank
    fp16_vec_bank #(
      .N (N),
      .W (W)
    ) u_bank (
      .clk         (clk),
      .rst         (rst),
      .wr_en       (w_wr_sel[b]),
      .wr_idx      (r_cnt),
      .wr_data     (bus.in_data),
      .wr_complete (w_complete),
      .wr_count    (w_wr_count),
      .clr         (w_clr_sel[b]),
      .full        (w_full[b]),
      .count       (w_count[b]),
      .data        (w_data[b])
    );
  end

  // Fill counter and bank pointers; completion and read handshake are independent
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt     <= '0;
      r_wr_bank <= 1'b0;
      r_rd_bank <= 1'b0;
    end else begin
      if (w_beat) begin
        r_cnt <= w_complete ? '0 : r_cnt + IW'(1);
      end
      if (w_complete) begin
        r_wr_bank <= ~r_wr_bank;
      end
      if (w_rd_hs) begin
        r_rd_bank <= ~r_rd_bank;
      end
    end
  end

  // Wide side is driven straight from bank registers, so it holds while stalled
  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = w_out_valid;
  assign bus.out_data  = w_data[r_rd_bank];
  assign bus.out_count = w_out_valid ? w_count[r_rd_bank] : '0;

endmodule : fp16_vec64_packer
`default_nettype wire

// File: tb/tb_fp16_vec64_packer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_fp16_vec64_packer
//  Purpose  : Self-checking bench for fp16_vec64_packer against a
//             queue-of-vectors reference model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_fp16_vec64_packer;

  localparam int N = 64;
  localparam int W = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  fp16_vec64_packer_if #(.N(N), .W(W)) bus ();

  fp16_vec64_packer #(.N(N), .W(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: completed vectors waiting for the tree, plus the one being filled
  logic [N*W-1:0] exp_vec_q [$];
  int             exp_cnt_q [$];
  logic [N*W-1:0] cur_vec;
  int             cur_n;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Compare every visible output with what the model says should be there
  task automatic check_outputs();
    logic [N*W-1:0] e;
    logic [N*W-1:0] o;
    check_val("in_ready", 32'(bus.in_ready), 32'(exp_vec_q.size() < 2));
    check_val("out_valid", 32'(bus.out_valid), 32'(exp_vec_q.size() > 0));
    if (exp_vec_q.size() > 0) begin
      e = exp_vec_q[0];
      o = bus.out_data;
      check_val("out_count", 32'(bus.out_count), 32'(exp_cnt_q[0]));
      for (int i = 0; i < N; i++) begin
        check_val($sformatf("slot%0d", i), 32'(o[i*W +: W]), 32'(e[i*W +: W]));
      end
    end else begin
      check_val("out_count_idle", 32'(bus.out_count), 32'd0);
    end
  endtask

  task automatic model_clear();
    exp_vec_q.delete();
    exp_cnt_q.delete();
    cur_vec = '0;
    cur_n   = 0;
  endtask

  // One clock: check at the falling edge, drive, then advance the model at the rising edge
  task automatic cyc(input logic v, input logic [W-1:0] d, input logic last, input logic ordy);
    bit beat;
    bit hs;
    @(negedge clk);
    check_outputs();
    bus.in_valid  = v;
    bus.in_data   = d;
    bus.in_last   = last;
    bus.out_ready = ordy;
    @(posedge clk);
    beat = v && (exp_vec_q.size() < 2);
    hs   = (exp_vec_q.size() > 0) && ordy;
    if (hs) begin
      void'(exp_vec_q.pop_front());
      void'(exp_cnt_q.pop_front());
    end
    if (beat) begin
      cur_vec[cur_n*W +: W] = d;
      cur_n++;
      if (cur_n == N || last) begin
        exp_vec_q.push_back(cur_vec);
        exp_cnt_q.push_back(cur_n);
        cur_vec = '0;
        cur_n   = 0;
      end
    end
  endtask

  task automatic idle(input int n, input logic ordy);
    for (int i = 0; i < n; i++) cyc(1'b0, 16'h0, 1'($urandom_range(0, 1)), ordy);
  endtask

  // Asynchronous reset between edges; outputs must clear without a clock
  task automatic do_reset();
    logic [N*W-1:0] o;
    @(negedge clk);
    bus.in_valid  = 1'b0;
    bus.in_last   = 1'b0;
    bus.out_ready = 1'b0;
    #1 rst = 1'b1;
    #1;
    o = bus.out_data;
    check_val("rst_in_ready", 32'(bus.in_ready), 32'd1);
    check_val("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check_val("rst_out_count", 32'(bus.out_count), 32'd0);
    for (int i = 0; i < N; i++) begin
      check_val($sformatf("rst_slot%0d", i), 32'(o[i*W +: W]), 32'd0);
    end
    model_clear();
    @(posedge clk);
    #2 rst = 1'b0;
  endtask

  initial begin
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.in_last   = 1'b0;
    bus.out_ready = 1'b0;
    model_clear();
    do_reset();

    // Full vector of 1.0
    for (int i = 0; i < N; i++) cyc(1'b1, 16'h3C00, 1'b0, 1'b1);
    idle(3, 1'b1);

    // Short vector of 2.0, five elements
    for (int i = 0; i < 5; i++) cyc(1'b1, 16'h4000, 1'(i == 4), 1'b1);
    idle(3, 1'b1);

    // Backpressure: two full vectors with the tree stalled
    for (int i = 0; i < 2*N; i++) cyc(1'b1, 16'($urandom), 1'b0, 1'b0);
    idle(3, 1'b0);
    cyc(1'b0, 16'h0, 1'b0, 1'b1);
    idle(3, 1'b0);
    idle(3, 1'b1);

    // Overlap: second vector completes on the first vector's handshake
    for (int i = 0; i < N; i++) cyc(1'b1, 16'($urandom), 1'b0, 1'b0);
    for (int i = 0; i < N-1; i++) cyc(1'b1, 16'($urandom), 1'b0, 1'b0);
    cyc(1'b1, 16'($urandom), 1'b0, 1'b1);
    idle(4, 1'b1);

    // Reset mid-fill, then a clean full vector
    for (int i = 0; i < 30; i++) cyc(1'b1, 16'($urandom), 1'b0, 1'b1);
    do_reset();
    for (int i = 0; i < N; i++) cyc(1'b1, 16'($urandom), 1'b0, 1'b1);
    idle(3, 1'b1);

    // Back-to-back single-element vectors
    for (int i = 0; i < 20; i++) cyc(1'b1, 16'($urandom), 1'b1, 1'b1);
    idle(3, 1'b1);

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      cyc(1'($urandom_range(0, 3) != 0), 16'($urandom),
          1'($urandom_range(0, 15) == 0), 1'($urandom_range(0, 2) != 0));
    end
    idle(6, 1'b1);
    @(negedge clk);
    check_outputs();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_fp16_vec64_packer
`default_nettype wire
